// File: rtl/pattern_sweep_capture.sv
// Exhaustive stimulus sweep: applies every N_IN-bit pattern in a selectable order,
// captures the response into a valid/ready record and folds each record into a MISR.
module pattern_sweep_capture #(
  parameter int                N_IN   = 3,
  parameter int                N_OUT  = 1,
  parameter int                SETTLE = 1,
  parameter int                MISR_W = 16,
  parameter logic [MISR_W-1:0] POLY   = 16'h1021
) (
  input  logic                    CK,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              mode,
  output logic [N_IN-1:0]         stim,
  input  logic [N_OUT-1:0]        resp,
  output logic                    rec_valid,
  input  logic                    rec_ready,
  output logic [N_IN+N_OUT-1:0]   rec_data,
  output logic                    busy,
  output logic                    done,
  output logic [MISR_W-1:0]       signature
);

  localparam int              REC_W       = N_IN + N_OUT;
  localparam logic [N_IN-1:0] LAST_INDEX  = {N_IN{1'b1}};
  localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_PRESENT,
    ST_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_launch;
  logic              w_sample;
  logic              w_advance;
  logic              w_busy;
  logic              w_done;
  logic              w_rec_valid;

  logic [1:0]        r_mode;
  logic [N_IN-1:0]   r_index;
  logic [N_IN-1:0]   w_next_index;
  logic [7:0]        r_settle;
  logic [N_IN-1:0]   r_stim;
  logic [REC_W-1:0]  r_rec_data;
  logic [REC_W-1:0]  w_record;
  logic [MISR_W-1:0] r_sig;

  // Sweep order; mode 3 falls through to ascending. Descending is the bitwise
  // complement, which equals (2^N_IN-1)-idx for an N_IN-bit index.
  function automatic logic [N_IN-1:0] pattern_of(input logic [1:0]      m,
                                                 input logic [N_IN-1:0] idx);
    case (m)
      2'd1:    return idx ^ (idx >> 1);
      2'd2:    return ~idx;
      default: return idx;
    endcase
  endfunction

  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] sig,
                                                  input logic [REC_W-1:0]  data);
    logic [MISR_W-1:0] fb;
    fb = sig[MISR_W-1] ? POLY : '0;
    return {sig[MISR_W-2:0], 1'b0} ^ fb ^ MISR_W'(data);
  endfunction

  assign w_next_index = r_index + N_IN'(1);
  assign w_record     = {r_stim, resp};

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of its peers; blocking here would create order-dependent races.
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default before the case statement, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_launch     = 1'b0;
    w_sample     = 1'b0;
    w_advance    = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_rec_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_launch     = 1'b1;
          w_next_state = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (r_settle == SETTLE_LAST) begin
          w_sample     = 1'b1;
          w_next_state = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        w_rec_valid = 1'b1;
        if (rec_ready) begin
          if (r_index == LAST_INDEX) begin
            w_next_state = ST_DONE;
          end else begin
            w_advance    = 1'b1;
            w_next_state = ST_APPLY;
          end
        end
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_mode     <= 2'd0;
      r_index    <= '0;
      r_settle   <= 8'd0;
      r_stim     <= '0;
      r_rec_data <= '0;
      r_sig      <= '0;
    end else begin
      if (w_launch) begin
        r_mode   <= mode;
        r_index  <= '0;
        r_settle <= 8'd0;
        r_sig    <= '0;
        r_stim   <= pattern_of(mode, '0);
      end
      if (r_state == ST_APPLY) begin
        r_settle <= w_sample ? 8'd0 : r_settle + 8'd1;
      end
      // Response is captured on the last settle cycle, together with the MISR fold.
      if (w_sample) begin
        r_rec_data <= w_record;
        r_sig      <= misr_next(r_sig, w_record);
      end
      if (w_advance) begin
        r_index <= w_next_index;
        r_stim  <= pattern_of(r_mode, w_next_index);
      end
    end
  end

  assign stim      = r_stim;
  assign rec_data  = r_rec_data;
  assign signature = r_sig;
  assign busy      = w_busy;
  assign done      = w_done;
  assign rec_valid = w_rec_valid;

  a_record_hold: assert property (@(posedge CK) disable iff (!reset)
    (rec_valid && !rec_ready) |=> (rec_valid && $stable(rec_data) && $stable(stim)));

  a_done_pulse: assert property (@(posedge CK) disable iff (!reset)
    done |=> !done);

endmodule

// File: doc/pattern_sweep_capture.md
PATTERN_SWEEP_CAPTURE -- requirements
Module: pattern_sweep_capture

Interface
REQ-001 The module SHALL have parameter N_IN, default 3, giving the stimulus width in bits (1..16).
REQ-002 The module SHALL have parameter N_OUT, default 1, giving the captured response width in bits (1..16).
REQ-003 The module SHALL have parameter SETTLE, default 1, giving the cycles each pattern is held before sampling (1..255).
REQ-004 The module SHALL have parameter MISR_W, default 16, giving the signature width (MISR_W >= N_IN+N_OUT).
REQ-005 The module SHALL have parameter POLY, default 16'h1021, giving the MISR feedback polynomial.
REQ-006 Port CK, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-low reset.
REQ-008 Port start, input, 1: sweep request, sampled in IDLE only.
REQ-009 Port mode, input, 2: sweep order, latched at start (0 ascending binary, 1 Gray, 2 descending binary, 3 treated as 0).
REQ-010 Port stim, output, N_IN: pattern driven to the device under test.
REQ-011 Port resp, input, N_OUT: device-under-test response.
REQ-012 Port rec_valid, output, 1: record available.
REQ-013 Port rec_ready, input, 1: consumer accepts the record.
REQ-014 Port rec_data, output, N_IN+N_OUT: record {stim, sampled resp}, stim in MSBs.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port done, output, 1: one-cycle pulse at sweep completion.
REQ-017 Port signature, output, MISR_W: MISR contents.

Function
REQ-018 The FSM SHALL have states IDLE, APPLY, PRESENT and DONE.
REQ-019 In IDLE with start=1, the block SHALL latch mode, clear index, settle counter and signature to 0, and enter APPLY next cycle.
REQ-020 On entering APPLY, stim SHALL equal f(index): index (mode 0), index^(index>>1) (mode 1), or (2^N_IN-1)-index (mode 2).
REQ-021 APPLY SHALL last exactly SETTLE cycles, then go to PRESENT.
REQ-022 On the APPLY->PRESENT edge, resp SHALL be registered into rec_data.
REQ-023 On the same edge, the MISR SHALL update as sig = (sig<<1) ^ (sig[MSB] ? POLY : 0) ^ zero-extended {stim, resp}.
REQ-024 In PRESENT, rec_valid SHALL be 1, with rec_data and stim held stable until rec_ready=1.
REQ-025 When rec_ready=1 in PRESENT and index is not 2^N_IN-1, the block SHALL increment index and re-enter APPLY.
REQ-026 When rec_ready=1 in PRESENT and index is 2^N_IN-1, the block SHALL enter DONE without wrapping the index.
REQ-027 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-028 stim and signature SHALL hold their final values in IDLE until the next start.
REQ-029 start SHALL be ignored while busy=1, and changes to mode SHALL be ignored while busy=1.
REQ-030 With rec_ready held at 1, a sweep SHALL take 2^N_IN*(SETTLE+1) cycles from APPLY entry to DONE.
REQ-031 Latency from start to the first rec_valid SHALL be SETTLE+1 cycles.
REQ-032 Exactly 2^N_IN records SHALL be produced per sweep, with no duplicates or omissions.

Reset
REQ-033 With reset=0, the block SHALL immediately force IDLE, and drive stim, rec_data, signature, index and settle counter to 0 and rec_valid, busy and done to 0.
REQ-034 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; after release the block SHALL wait in IDLE for a new start.
REQ-035 Release of reset SHALL be synchronous to CK, and start sampled in the release cycle SHALL be honoured.

Verification
REQ-036 Defaults, mode 0, resp=0, rec_ready=1, one start pulse -> stim runs 0..7, 8 records {stim,0}, done pulses 16 cycles after APPLY entry, signature = 16'h001E.
REQ-037 N_IN=3, mode 1 -> stim sequence 0,1,3,2,6,7,5,4; mode 2 -> 7,6,...,0.
REQ-038 rec_ready held 0 for 5 cycles on the third record -> rec_valid, rec_data and stim stay stable, no record is lost, and total sweep time grows by 5 cycles.
REQ-039 start pulsed mid-sweep and mode changed mid-sweep -> no effect on the sequence or record count.
REQ-040 reset asserted during record 4 -> all outputs go to 0 immediately, no done pulse; a subsequent start produces a full clean sweep with signature 16'h001E.
REQ-041 SETTLE=3, resp=stim[0] -> each pattern is held 3 cycles, and rec_data LSB equals the stim LSB on every record.
